// File: rtl/coin_credit_fsm.sv
// Coin credit controller: synchronises coin switches, accumulates credit,
// vends at a fixed price and pays change or refunds on cancel.
module coin_credit_fsm #(
    parameter int                          N_COIN      = 4,
    parameter int                          COIN_W      = 8,
    parameter logic [N_COIN*COIN_W-1:0]    COIN_VALUES = 32'h64_32_0A_05,
    parameter int                          CREDIT_W    = 10,
    parameter int                          PRICE       = 120,
    parameter int                          MAX_CREDIT  = 500,
    parameter int                          SYNC_STAGES = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [N_COIN-1:0]   coin_in,
    input  logic                vend_req,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic [1:0]          fsm_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] VEND   = 2'd2;
    localparam logic [1:0] CHANGE = 2'd3;

    localparam int                  WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0]   WARM_DONE = WARM_W'(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0]   WARM_ONE  = WARM_W'(1);
    localparam logic [CREDIT_W:0]   MAX_EXT   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [N_COIN-1:0]   BIT0      = N_COIN'(1);

    logic [SYNC_STAGES-1:0][N_COIN-1:0] sync_q;
    logic [N_COIN-1:0]                  prev_q;
    logic [WARM_W-1:0]                  warm_q;

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_q, vend_d;
    logic                changeValid_q, changeValid_d;
    logic [CREDIT_W-1:0] changeAmt_q, changeAmt_d;
    logic                coinReject_q, coinReject_d;

    logic [N_COIN-1:0]   edges;
    logic [N_COIN-1:0]   selMask;
    logic [COIN_W-1:0]   selValue;
    logic [CREDIT_W:0]   sum;
    logic                coinWindow;
    logic                accept;

    // Edges stay masked until the synchroniser has refilled after reset, so a
    // switch already high at reset release never counts as a deposit.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], coin_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + WARM_ONE;
            end
        end
    end

    assign edges = (warm_q == WARM_DONE) ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;

    always_comb begin
        selMask  = '0;
        selValue = '0;
        for (int i = N_COIN - 1; i >= 0; i--) begin
            if (edges[i]) begin
                selMask  = BIT0 << i;
                selValue = COIN_VALUES[i*COIN_W +: COIN_W];
            end
        end
    end

    assign sum          = {1'b0, credit_q} + (CREDIT_W + 1)'(selValue);
    assign coinWindow   = ((state_q == IDLE) || (state_q == ACCUM)) && !vend_req && !cancel;
    assign accept       = coinWindow && (|edges) && (sum <= MAX_EXT);
    assign coinReject_d = accept ? |(edges & ~selMask) : |edges;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_d        = 1'b0;
        changeValid_d = 1'b0;
        changeAmt_d   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    credit_d = sum[CREDIT_W-1:0];
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (cancel) begin
                    state_d       = CHANGE;
                    changeValid_d = 1'b1;
                    changeAmt_d   = credit_q;
                end else if (vend_req && (credit_q >= PRICE_C)) begin
                    state_d = VEND;
                    vend_d  = 1'b1;
                end else if (accept) begin
                    credit_d = sum[CREDIT_W-1:0];
                end
            end
            VEND: begin
                credit_d = credit_q - PRICE_C;
                if (credit_q != PRICE_C) begin
                    state_d       = CHANGE;
                    changeValid_d = 1'b1;
                    changeAmt_d   = credit_q - PRICE_C;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                credit_d = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            vend_q        <= 1'b0;
            changeValid_q <= 1'b0;
            changeAmt_q   <= '0;
            coinReject_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_q        <= vend_d;
            changeValid_q <= changeValid_d;
            changeAmt_q   <= changeAmt_d;
            coinReject_q  <= coinReject_d;
        end
    end

    assign credit       = credit_q;
    assign vend         = vend_q;
    assign change_valid = changeValid_q;
    assign change_amt   = changeAmt_q;
    assign coin_reject  = coinReject_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Bench for coin_credit_fsm: directed test-plan steps followed by random
// coin/vend/cancel operations, all checked against an arithmetic credit model.
module tb_coin_credit_fsm;

    localparam int PRICE = 120;
    localparam int MAXC  = 500;
    localparam int LAT   = 3;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [3:0] coin_in;
    logic       vend_req;
    logic       cancel;
    logic [9:0] credit;
    logic       vend;
    logic       change_valid;
    logic [9:0] change_amt;
    logic       coin_reject;
    logic [1:0] fsm_state;

    int vectors     = 0;
    int miscompares = 0;
    int modelCredit = 0;
    int coinVal [4] = '{5, 10, 50, 100};

    coin_credit_fsm dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .coin_in      (coin_in),
        .vend_req     (vend_req),
        .cancel       (cancel),
        .credit       (credit),
        .vend         (vend),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .fsm_state    (fsm_state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // A negative expCredit means credit is not compared at that point.
    task automatic checkAll(input string tag, input int expCredit, input int expState,
                            input logic expVend, input logic expCv, input int expAmt, input logic expRej);
        if (expCredit >= 0) checkOutput({tag, ".credit"}, credit, expCredit);
        checkOutput({tag, ".state"},  fsm_state,    expState);
        checkOutput({tag, ".vend"},   vend,         expVend);
        checkOutput({tag, ".cv"},     change_valid, expCv);
        checkOutput({tag, ".amt"},    change_amt,   expAmt);
        checkOutput({tag, ".reject"}, coin_reject,  expRej);
    endtask

    function automatic int idleOrAccum();
        return (modelCredit > 0) ? 1 : 0;
    endfunction

    // kind 0 = raise coin mask, 1 = vend request, 2 = cancel
    task automatic applyStimulus(input int kind, input logic [3:0] mask, input string tag);
        int  lowest;
        int  nEdges;
        int  oldCredit;
        int  remainder;
        bit  acc;
        case (kind)
            0: begin
                lowest = -1;
                nEdges = 0;
                for (int i = 0; i < 4; i++) begin
                    if (mask[i]) begin
                        nEdges++;
                        if (lowest < 0) lowest = i;
                    end
                end
                acc       = (lowest >= 0) && (modelCredit + coinVal[lowest] <= MAXC);
                oldCredit = modelCredit;
                if (acc) modelCredit += coinVal[lowest];
                coin_in = mask;
                repeat (LAT - 1) tick();
                checkOutput({tag, ".early"}, credit, oldCredit);
                tick();
                checkAll(tag, modelCredit, idleOrAccum(), 1'b0, 1'b0, 0, (nEdges - (acc ? 1 : 0)) > 0);
                coin_in = '0;
                tick();
                checkAll({tag, ".after"}, modelCredit, idleOrAccum(), 1'b0, 1'b0, 0, 1'b0);
                repeat (LAT) tick();
            end
            1: begin
                vend_req = 1'b1;
                tick();
                vend_req = 1'b0;
                if (modelCredit >= PRICE) begin
                    checkAll({tag, ".vend"}, modelCredit, 2, 1'b1, 1'b0, 0, 1'b0);
                    remainder = modelCredit - PRICE;
                    tick();
                    if (remainder > 0) begin
                        checkAll({tag, ".change"}, -1, 3, 1'b0, 1'b1, remainder, 1'b0);
                        tick();
                    end
                    modelCredit = 0;
                    checkAll({tag, ".done"}, 0, 0, 1'b0, 1'b0, 0, 1'b0);
                end else begin
                    checkAll({tag, ".ignored"}, modelCredit, idleOrAccum(), 1'b0, 1'b0, 0, 1'b0);
                end
            end
            default: begin
                cancel = 1'b1;
                tick();
                cancel = 1'b0;
                if (modelCredit > 0) begin
                    checkAll({tag, ".refund"}, -1, 3, 1'b0, 1'b1, modelCredit, 1'b0);
                    tick();
                    modelCredit = 0;
                    checkAll({tag, ".done"}, 0, 0, 1'b0, 1'b0, 0, 1'b0);
                end else begin
                    checkAll({tag, ".ignored"}, 0, 0, 1'b0, 1'b0, 0, 1'b0);
                end
            end
        endcase
    endtask

    initial begin
        logic [3:0] mask;
        int         op;

        reset    = 1'b1;
        coin_in  = 4'b1000;
        vend_req = 1'b0;
        cancel   = 1'b0;
        repeat (3) tick();
        checkAll("reset.hold", 0, 0, 1'b0, 1'b0, 0, 1'b0);
        reset = 1'b0;
        modelCredit = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkAll($sformatf("reset.release%0d", i), 0, 0, 1'b0, 1'b0, 0, 1'b0);
        end
        coin_in = '0;
        repeat (LAT + 1) tick();

        applyStimulus(0, 4'b1000, "exact.c100");
        applyStimulus(0, 4'b0010, "exact.c10a");
        applyStimulus(0, 4'b0010, "exact.c10b");
        applyStimulus(1, 4'b0000, "exact");

        applyStimulus(0, 4'b1000, "chg.c100");
        applyStimulus(0, 4'b0100, "chg.c50");
        applyStimulus(1, 4'b0000, "chg");

        applyStimulus(0, 4'b0100, "insuf.c50");
        applyStimulus(1, 4'b0000, "insuf");
        applyStimulus(2, 4'b0000, "insuf.cancel");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 4'b1000, $sformatf("ovf.c100_%0d", i));
        end
        checkOutput("ovf.ceiling", credit, MAXC);
        applyStimulus(2, 4'b0000, "ovf.cancel");
        applyStimulus(0, 4'b0101, "multi");
        applyStimulus(2, 4'b0000, "multi.cancel");

        applyStimulus(2, 4'b0000, "idle.cancel");
        applyStimulus(1, 4'b0000, "idle.vend");

        applyStimulus(0, 4'b1000, "rstmid.c100");
        applyStimulus(0, 4'b0100, "rstmid.c50");
        vend_req = 1'b1;
        tick();
        vend_req = 1'b0;
        checkAll("rstmid.vend", 150, 2, 1'b1, 1'b0, 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkAll("rstmid.async", 0, 0, 1'b0, 1'b0, 0, 1'b0);
        tick();
        reset = 1'b0;
        modelCredit = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkAll($sformatf("rstmid.post%0d", i), 0, 0, 1'b0, 1'b0, 0, 1'b0);
        end

        for (int n = 0; n < 50; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(1, 15));
                else                           mask = 4'(1 << $urandom_range(0, 3));
                applyStimulus(0, mask, $sformatf("rnd%0d.coin", n));
            end else if (op <= 7) begin
                applyStimulus(1, 4'b0000, $sformatf("rnd%0d.vreq", n));
            end else begin
                applyStimulus(2, 4'b0000, $sformatf("rnd%0d.canc", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coin_credit_fsm.md
Name: coin_credit_fsm

Overview:
- Parametrised successor to the fixed 3-bit coin-state machine: accumulates credit from N_COIN debounced coin switches, vends at a programmable price, returns change and supports cancel/refund.
- Sits between the board switch inputs and the 7-segment display logic; the display path consumes credit and change_amt.
- Replaces OR-of-switches clocking with a single system clock, input synchronisers and rising-edge detection.

Parameters:
N_COIN, 4, number of coin input channels
COIN_W, 8, width of each coin value
COIN_VALUES, 32'h64_32_0A_05, packed coin values; coin i value = COIN_VALUES[i*COIN_W +: COIN_W] (default: coin0=5, coin1=10, coin2=50, coin3=100)
CREDIT_W, 10, width of the credit and change registers
PRICE, 120, cost of one vend
MAX_CREDIT, 500, credit ceiling; must be < 2**CREDIT_W
SYNC_STAGES, 2, synchroniser depth on coin_in (minimum 2)

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
coin_in  in  N_COIN  raw switch levels, asynchronous; a rising edge on bit i means coin i was deposited
vend_req  in  1  synchronous single-cycle vend request
cancel  in  1  synchronous single-cycle refund request
credit  out  CREDIT_W  current accumulated credit, registered
vend  out  1  one-cycle pulse when an item is dispensed
change_valid  out  1  one-cycle pulse when change or a refund is paid
change_amt  out  CREDIT_W  change value; valid only while change_valid, 0 otherwise
coin_reject  out  1  one-cycle pulse when a coin edge is refused
fsm_state  out  2  encoded state: IDLE=0, ACCUM=1, VEND=2, CHANGE=3

Behaviour:
- Reset (asynchronous, any time including mid-vend): all synchroniser and edge flops = 0, credit = 0, vend = change_valid = coin_reject = 0, change_amt = 0, fsm_state = IDLE. No pulse is emitted on reset release, even if coin_in is already high.
- Synchroniser: SYNC_STAGES flops per bit, followed by one previous-value flop. Edge i = synced_i & ~prev_i.
- Latency: credit changes on the (SYNC_STAGES+1)-th rising CLOCK_50 edge after coin_in rises, assuming setup is met.
- Coin accept happens only in IDLE or ACCUM, and only when vend_req and cancel are both low in that cycle.
- Multiple edges in one cycle: the lowest-index edge is considered. Every other edge in that cycle is rejected, so coin_reject = 1.
- Overflow: if credit + value > MAX_CREDIT, the coin is rejected and credit is unchanged. A sum exactly equal to MAX_CREDIT is accepted.
- Any edge in VEND or CHANGE is rejected.
- IDLE: credit == 0. An accepted coin moves to ACCUM. vend_req and cancel are ignored.
- ACCUM transitions, in priority order:
  - cancel: go to CHANGE, refund = credit.
  - vend_req with credit >= PRICE: go to VEND.
  - vend_req with credit < PRICE: ignored, stay in ACCUM, no pulse.
  - Otherwise, accepted coins add to credit.
- VEND (one cycle): vend = 1 and credit <= credit - PRICE.
  - Remainder > 0: go to CHANGE.
  - Remainder = 0: go to IDLE.
- CHANGE (one cycle): change_valid = 1, change_amt = amount owed, credit <= 0. Next state is IDLE.
- All outputs are registered. Pulses are exactly one cycle wide. vend and change_valid are never high in the same cycle.
- Arithmetic: unsigned, CREDIT_W bits. The overflow compare uses CREDIT_W+1 bits so the sum cannot wrap.

Test Plan:
- Reset and idle: assert reset while coin_in = 4'b1000 held, then release -> no coin accepted, credit = 0, fsm_state = 0, no pulses.
- Exact vend:
  - Stimulus: coin3 (100), then coin1 (10) twice, then vend_req.
  - Credit sequence: 100, 110, 120.
  - Response: vend pulse, credit goes to 0, no change_valid, return to IDLE.
- Vend with change:
  - Stimulus: coin3 (100) + coin2 (50) = 150, then vend_req.
  - Response: vend pulse, next cycle change_valid = 1 with change_amt = 30, credit = 0, IDLE.
- Insufficient credit then cancel:
  - Stimulus: coin2 (50), then vend_req.
  - Required: no vend, credit stays 50.
  - Then cancel -> change_valid = 1, change_amt = 50, credit = 0.
- Overflow and simultaneous edges:
  - Stimulus: five coin3 edges.
  - Required: credit = 500. A sixth coin3 -> coin_reject pulse, credit stays 500.
  - Then from credit 0, raise coin0 and coin2 in the same cycle -> credit = 5, coin_reject pulse.
- Reset mid-operation: assert reset during the VEND cycle (credit 150) -> vend and change_valid deassert immediately, credit = 0, IDLE, and no change pulse after release.
